// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler.
// Tracks pending writes per register (busy scoreboard) to hold issue on
// RAW/WAW hazards, shares the single register-file write port between the
// ALU (wb0) and load (wb1) writeback paths with round-robin arbitration, and
// quiesces outstanding writes before the register dump is triggered.
module regfile_wb_scheduler #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  // decode / issue
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rs1,
  input  logic [4:0]                issue_rs2,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_wr,
  output logic                      issue_ready,
  // ALU writeback
  input  logic                      wb0_valid,
  input  logic [4:0]                wb0_rd,
  input  logic [BUS_DATA_WIDTH-1:0] wb0_data,
  output logic                      wb0_ready,
  // load writeback
  input  logic                      wb1_valid,
  input  logic [4:0]                wb1_rd,
  input  logic [BUS_DATA_WIDTH-1:0] wb1_data,
  output logic                      wb1_ready,
  // register-file write port
  output logic                      rf_wr_en,
  output logic [4:0]                rf_rd,
  output logic [BUS_DATA_WIDTH-1:0] rf_data,
  // status / drain
  output logic [31:0]               busy_vec,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      wb_err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [31:0]               busy;
  logic [31:0]               busy_nxt;
  logic                      favor_wb1;   // both valid: wb1 wins when set
  logic                      grant0;
  logic                      grant1;
  logic                      wb_fire;
  logic                      issue_fire;
  logic [4:0]                acc_rd;
  logic [BUS_DATA_WIDTH-1:0] acc_data;

  assign busy_vec   = busy;
  assign issue_fire = issue_valid && issue_ready;
  assign wb0_ready  = grant0;
  assign wb1_ready  = grant1;
  assign wb_fire    = grant0 || grant1;
  assign acc_rd     = grant1 ? wb1_rd   : wb0_rd;
  assign acc_data   = grant1 ? wb1_data : wb0_data;

  // Issue may fire only while running and when no source or destination
  // register has a write outstanding.
  always_comb begin
    issue_ready = (state == RUN) &&
                  !busy[issue_rs1] && !busy[issue_rs2] &&
                  !(issue_wr && busy[issue_rd]);
  end

  // Round-robin arbitration: a lone requester always wins; on contention
  // the source that was not granted last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (wb0_valid && wb1_valid) begin
      grant0 = !favor_wb1;
      grant1 = favor_wb1;
    end else begin
      grant0 = wb0_valid;
      grant1 = wb1_valid;
    end
  end

  // Scoreboard update: the write in progress clears its bit, a new issue
  // sets its bit afterwards so the set wins on a collision; x0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (rf_wr_en) begin
      busy_nxt[rf_rd] = 1'b0;
    end
    if (issue_fire && issue_wr) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard, write port, arbitration pointer and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the scoreboard is a plain flop vector rather than a RAM array,
      // so it can be cleared in a single reset cycle.
      busy      <= '0;
      rf_wr_en  <= 1'b0;
      rf_rd     <= '0;
      rf_data   <= '0;
      favor_wb1 <= 1'b0;
      wb_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      busy     <= busy_nxt;
      rf_wr_en <= wb_fire && (acc_rd != 5'd0);
      if (wb_fire && (acc_rd != 5'd0)) begin
        rf_rd   <= acc_rd;
        rf_data <= acc_data;
      end
      if (wb_fire) begin
        favor_wb1 <= grant0;
      end
      if (wb_fire && (acc_rd != 5'd0) && !busy[acc_rd]) begin
        wb_err <= 1'b1;
      end
    end
  end

  // Drain sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain sequencer: stop issue, let writes retire, pulse drain_done once,
  // then hold until the request is withdrawn.
  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((busy == 32'd0) && !rf_wr_en) state_nxt = DONE;
      end
      DONE: begin
        drain_done = 1'b1;
        state_nxt  = HALT;
      end
      HALT: begin
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the 32x64 integer register file: a per-register busy scoreboard gates instruction issue on RAW/WAW hazards.
- Round-robin arbitration shares the single register-file write port between two writeback sources: wb0 (ALU) and wb1 (load unit).
- A drain sequencer quiesces outstanding writes before the register dump (display_regs) is triggered.
- Sits between decode/issue, the execute/memory writeback paths, and the register file write port.

Parameters:
- BUS_DATA_WIDTH, 64, width of writeback data and register-file write data.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_rd  in  5  destination register.
- issue_wr  in  1  instruction will write issue_rd.
- issue_ready  out  1  issue may fire this cycle (combinational).
- wb0_valid  in  1  ALU writeback request.
- wb0_rd  in  5  ALU destination.
- wb0_data  in  BUS_DATA_WIDTH  ALU result.
- wb0_ready  out  1  wb0 granted this cycle (combinational).
- wb1_valid  in  1  load writeback request.
- wb1_rd  in  5  load destination.
- wb1_data  in  BUS_DATA_WIDTH  load result.
- wb1_ready  out  1  wb1 granted this cycle (combinational).
- rf_wr_en  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write index (registered).
- rf_data  out  BUS_DATA_WIDTH  register-file write data (registered).
- busy_vec  out  32  scoreboard; bit i set means a write to xi is pending.
- drain_req  in  1  request quiesce before register dump.
- drain_done  out  1  one-cycle pulse when quiesced; drives display_regs.
- wb_err  out  1  sticky: a writeback targeted a non-busy nonzero register.

Behaviour:
- Reset values: busy_vec=0, rf_wr_en=0, rf_rd=0, rf_data=0, drain_done=0, wb_err=0, state=RUN, round-robin pointer favours wb0.
- Reset mid-operation discards any pending grant or write. rf_wr_en is low in the cycle after reset.
- Fire rules: issue fires on issue_valid && issue_ready. wbN fires on wbN_valid && wbN_ready.
- issue_ready = (state==RUN) && !busy[rs1] && !busy[rs2] && !(issue_wr && busy[rd]).
- busy[0] is constant 0, so x0 never stalls issue.
- Issue fire with issue_wr and rd!=0 sets busy[rd] at the clock edge.
- Arbitration: at most one grant per cycle.
  - Only one source valid: that source is granted.
  - Both valid: grant the source not granted last.
  - The pointer updates only when a grant fires.
  - No valid source: no ready is asserted.
- Write latency: a source accepted in cycle t appears at the port in cycle t+1.
  - rf_wr_en=1, rf_rd and rf_data are driven with the accepted request in t+1.
  - Exception: rd==0 gives rf_wr_en=0, but the request is still accepted and consumed.
  - With no acceptance in t, rf_wr_en=0 in t+1 and rf_rd/rf_data hold their values.
- busy[rf_rd] clears at the end of the cycle in which rf_wr_en=1, the same edge the register file captures the data.
  - The dependent instruction may issue in t+2 and reads the new value.
  - Issue in t+1 stalls.
- Simultaneous events:
  - Issue setting busy[r] on the same edge a write clears busy[r]: set wins.
  - An accepted writeback whose rd is nonzero and not busy at acceptance sets wb_err. The write is still performed.
  - wb_err clears only on reset.
- Drain state machine:
  - RUN: drain_req=1 -> DRAIN. issue_ready is forced 0 in every state except RUN.
  - DRAIN: writebacks are still arbitrated and written. When busy_vec==0 && rf_wr_en==0 -> DONE.
  - DONE: drain_done=1 for exactly one cycle -> HALT.
  - HALT: drain_done=0. drain_req=0 -> RUN, otherwise stay.
  - drain_req dropped during DRAIN does not abort; the sequence completes.
  - drain_req with busy_vec already 0 and rf_wr_en=0 gives RUN->DRAIN->DONE, so drain_done pulses 2 cycles after the request.

Test Plan:
- Issue rd=5 wr; next cycle issue rs1=5 -> issue_ready=0. wb0 x5=0x1234 in cycle t -> rf_wr_en=1, rf_rd=5, rf_data=0x1234 in t+1; busy_vec[5]=0 and issue_ready=1 in t+2.
- wb0 and wb1 both valid for 4 cycles (x3, x7 pending, rds distinct) -> grants alternate wb0,wb1,wb0,wb1 with one write per cycle; a lone wb1 request is granted immediately.
- Issue rd=0 wr, then issue rs1=0 -> no stall, busy_vec stays 0. wb1 x0=0xFF -> wb1_ready=1, rf_wr_en=0 next cycle, wb_err stays 0.
- Same-edge case: busy[9] set and its write in flight; issue rd=9 wr in the write cycle -> the WAW check stalls issue. Forcing the set/clear collision via a non-busy wb, then issuing, leaves busy[9]=1 (set wins) and wb_err=1.
- drain_req with x4 and x8 pending -> issue_ready=0; wbs complete; drain_done pulses one cycle after the last write cycle+1; HALT holds until drain_req=0, then RUN restores issue_ready.
- Reset asserted the cycle after a wb0 acceptance -> rf_wr_en=0, busy_vec=0, wb_err=0, state RUN on the following cycle.
